// File: rtl/ram_dp_param.sv
// ram_dp_param
//   Simple-dual-port RAM on a single clock: one write port, one read port.
//   Width, depth and read latency are parameterised. Writes can be masked per bit.
//   Reads can be registered or combinational. For registered reads, the
//   same-address read-during-write result is selectable. A clear sequencer fills
//   every word with INIT_VAL after reset or when clr is pulsed.
//
// Parameters
//   WIDTH     data bits per word
//   AWIDTH    address bits, DEPTH = 2**AWIDTH
//   RDREG     1: registered read (latency 1), 0: combinational read
//   RDW_MODE  registered read on the write address: 0 old word, 1 merged new word
//   INIT_VAL  value written to every word by the clear sequence
//
// Ports
//   wclk    clock, all state changes on the rising edge
//   rst     synchronous active-high reset, starts a clear sequence
//   clr     pulse in IDLE to start a clear sequence
//   we      write enable, waddr/wdata/wmask write address, data, bit mask
//   re      read enable, raddr read address
//   rdata   read data, rvalid marks rdata as the result of an accepted read
//   busy    clear sequence in progress, port operations are ignored
module ram_dp_param #(
  parameter int                WIDTH    = 8,
  parameter int                AWIDTH   = 4,
  parameter int                RDREG    = 1,
  parameter int                RDW_MODE = 0,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]  wmask,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int                DEPTH    = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state_q;
  logic [AWIDTH-1:0]   ccnt_q;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic                mem_we;
  logic [AWIDTH-1:0]   mem_wa;
  logic [WIDTH-1:0]    mem_wd;
  logic                port_ok;

  // Bits set in mask take the new value, the rest keep the stored value.
  function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [WIDTH-1:0] mask);
    merge_word = (old_w & ~mask) | (new_w & mask);
  endfunction

  assign busy    = (state_q == ST_CLEAR);
  // A clr pulse claims its own cycle, so a write or read issued with it is dropped.
  assign port_ok = (state_q == ST_IDLE) && !clr && !rst;

  // Clear sequencer: walks ccnt through every address, then returns to IDLE.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ccnt_q  <= '0;
    end else if (state_q == ST_CLEAR) begin
      ccnt_q <= ccnt_q + 1'b1;
      if (ccnt_q == CNT_LAST) begin
        state_q <= ST_IDLE;
      end
    end else if (clr) begin
      state_q <= ST_CLEAR;
      ccnt_q  <= '0;
    end
  end

  // Single array write port shared by the clear sequencer and the user port.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = merge_word(mem[waddr], wdata, wmask);
    if (!rst && state_q == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = ccnt_q;
      mem_wd = INIT_VAL;
    end else if (port_ok && we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  if (RDREG != 0) begin : g_rdreg
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;
    logic             rvalid_q;
    logic             rvalid_d;
    logic             bypass;

    // New-data mode forwards the merged word when both ports hit the same address.
    assign bypass = (RDW_MODE != 0) && we && (waddr == raddr);

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (port_ok && re) begin
        rvalid_d = 1'b1;
        rdata_d  = bypass ? merge_word(mem[raddr], wdata, wmask) : mem[raddr];
      end
    end

    // Read stage boundary: rdata holds its value when no read is accepted.
    always_ff @(posedge wclk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_rdcomb
    assign rdata  = mem[raddr];
    assign rvalid = re & ~busy;
  end

endmodule

// File: tb/tb_ram_dp_param.sv
module tb_ram_dp_param;

  localparam int        D  = 16;
  localparam logic [7:0] IV = 8'hA5;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Port set A drives two registered-read instances (old-data and new-data RDW).
  logic       rst = 1'b1, clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [3:0] waddr = '0, raddr = '0;
  logic [7:0] wdata = '0, wmask = '0;
  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1, busy0, busy1;

  // Port set B drives the legacy 16x1 combinational-read instance.
  logic       rst_b = 1'b1, clr_b = 1'b0, we_b = 1'b0, re_b = 1'b0;
  logic [3:0] waddr_b = '0, raddr_b = '0;
  logic       wdata_b = 1'b0, wmask_b = 1'b0;
  logic       rdata_b, rvalid_b, busy_b;

  int n_vec = 0;
  int n_err = 0;

  ram_dp_param #(.WIDTH(8), .AWIDTH(4), .RDREG(1), .RDW_MODE(0), .INIT_VAL(8'hA5)) u_old (
    .wclk(wclk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0));

  ram_dp_param #(.WIDTH(8), .AWIDTH(4), .RDREG(1), .RDW_MODE(1), .INIT_VAL(8'hA5)) u_new (
    .wclk(wclk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));

  ram_dp_param #(.WIDTH(1), .AWIDTH(4), .RDREG(0), .RDW_MODE(0), .INIT_VAL(1'b0)) u_leg (
    .wclk(wclk), .rst(rst_b), .clr(clr_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .wmask(wmask_b), .re(re_b), .raddr(raddr_b), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b));

  // Reference model A: clear modelled as a countdown of words still to fill.
  logic [7:0] m_mem [D];
  int         m_left = 0;
  logic [7:0] m_rd_old = '0, m_rd_new = '0, m_mg;
  logic       m_rv = 1'b0;

  always @(posedge wclk) begin
    if (rst) begin
      m_left = D; m_rd_old = '0; m_rd_new = '0; m_rv = 1'b0;
    end else if (m_left > 0) begin
      m_mem[D - m_left] = IV; m_left = m_left - 1; m_rv = 1'b0;
    end else if (clr) begin
      m_left = D; m_rv = 1'b0;
    end else begin
      m_mg = (m_mem[waddr] & ~wmask) | (wdata & wmask);
      if (re) begin
        m_rd_old = m_mem[raddr];
        m_rd_new = (we && waddr == raddr) ? m_mg : m_mem[raddr];
        m_rv     = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (we) m_mem[waddr] = m_mg;
    end
  end

  // Reference model B: 1-bit words, init value 0.
  logic mb_mem [D];
  int   mb_left = 0;

  always @(posedge wclk) begin
    if (rst_b) mb_left = D;
    else if (mb_left > 0) begin
      mb_mem[D - mb_left] = 1'b0; mb_left = mb_left - 1;
    end else if (!clr_b && we_b)
      mb_mem[waddr_b] = (mb_mem[waddr_b] & ~wmask_b) | (wdata_b & wmask_b);
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    step(); step();
    n_vec++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state busy=%b rvalid=%b rdata0=%h rdata1=%h exp busy=1 rvalid=0 rdata=00",
               busy0, rvalid0, rdata0, rdata1);
    end
    n_vec++;
    if (busy_b !== 1'b1 || rvalid_b !== 1'b0) begin
      n_err++; $display("FAIL reset_state_leg busy=%b rvalid=%b exp 1 0", busy_b, rvalid_b);
    end
    rst = 1'b0; rst_b = 1'b0; re = 1'b1; re_b = 1'b1;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 40) begin
      raddr = 4'($urandom); raddr_b = 4'($urandom);
      #1;
      n_vec++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rvalid_b !== 1'b0 || busy_b !== 1'b1) begin
        n_err++;
        $display("FAIL busy_ignores_read rvalid=%b%b%b busy_b=%b exp 000 1",
                 rvalid0, rvalid1, rvalid_b, busy_b);
      end
      step();
      cnt++;
    end
    n_vec++;
    if (cnt !== D || busy_b !== 1'b0) begin
      n_err++; $display("FAIL clear_length got %0d cycles (busy_b=%b) exp 16 (0)", cnt, busy_b);
    end
    for (int i = 0; i < D; i++) begin
      raddr = 4'(i); raddr_b = 4'(i);
      #1;
      n_vec++;
      if (rdata_b !== 1'b0 || rvalid_b !== 1'b1) begin
        n_err++; $display("FAIL leg_cleared addr %0d got %b/%b exp 0/1", i, rdata_b, rvalid_b);
      end
      step();
      n_vec++;
      if (rdata0 !== IV || rdata1 !== IV || rvalid0 !== 1'b1) begin
        n_err++;
        $display("FAIL cleared_word addr %0d got %h/%h rvalid=%b exp a5 rvalid=1", i, rdata0, rdata1, rvalid0);
      end
    end
    re = 1'b0; re_b = 1'b0;
    step();
  endtask

  task automatic test_masked_write();
    we = 1'b1; waddr = 4'd3; wdata = 8'hFF; wmask = 8'hFF; step();
    wdata = 8'h00; wmask = 8'h0F; step();
    we = 1'b0; re = 1'b1; raddr = 4'd3; step();
    n_vec++;
    if (rdata0 !== 8'hF0 || rvalid0 !== 1'b1) begin
      n_err++; $display("FAIL masked_write got %h rvalid=%b exp f0 1", rdata0, rvalid0);
    end
    re = 1'b0; step();
    n_vec++;
    if (rdata0 !== 8'hF0 || rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL read_hold got %h rvalid=%b exp f0 0", rdata0, rvalid0);
    end
  endtask

  task automatic test_rdw();
    we = 1'b1; waddr = 4'd7; wdata = 8'h11; wmask = 8'hFF; step();
    re = 1'b1; raddr = 4'd7; wdata = 8'h3C; step();
    n_vec++;
    if (rdata0 !== 8'h11 || rdata1 !== 8'h3C) begin
      n_err++; $display("FAIL rdw got old=%h new=%h exp 11 3c", rdata0, rdata1);
    end
    we = 1'b0; step();
    n_vec++;
    if (rdata0 !== 8'h3C || rdata1 !== 8'h3C) begin
      n_err++; $display("FAIL rdw_after got %h %h exp 3c 3c", rdata0, rdata1);
    end
    re = 1'b0; step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom); re = 1'($urandom);
      waddr = 4'($urandom); wdata = 8'($urandom);
      wmask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      raddr = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom);
      step();
      n_vec++;
      if (rdata0 !== m_rd_old || rdata1 !== m_rd_new || rvalid0 !== m_rv || rvalid1 !== m_rv
          || busy0 !== 1'b0) begin
        n_err++;
        $display("FAIL random cyc %0d got %h %h %b%b busy=%b exp %h %h %b busy=0",
                 i, rdata0, rdata1, rvalid0, rvalid1, busy0, m_rd_old, m_rd_new, m_rv);
      end
    end
    we = 1'b0; re = 1'b0; step();
  endtask

  task automatic test_runtime_clr();
    int cnt;
    we = 1'b1; waddr = 4'd9; wdata = 8'h5A; wmask = 8'hFF; step();
    clr = 1'b1; waddr = 4'd2; wdata = 8'h33; step();
    clr = 1'b0; we = 1'b0;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 40) begin step(); cnt++; end
    n_vec++;
    if (cnt !== D) begin
      n_err++; $display("FAIL clr_length got %0d exp 16", cnt);
    end
    re = 1'b1; raddr = 4'd9; step();
    n_vec++;
    if (rdata0 !== IV) begin n_err++; $display("FAIL clr_addr9 got %h exp a5", rdata0); end
    raddr = 4'd2; step();
    n_vec++;
    if (rdata0 !== IV || rvalid0 !== 1'b1) begin
      n_err++; $display("FAIL clr_drop_write got %h rvalid=%b exp a5 1", rdata0, rvalid0);
    end
    re = 1'b0; step();
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    we = 1'b1; waddr = 4'd15; wdata = 8'h00; wmask = 8'hFF; step();
    we = 1'b0; waddr = 4'd0; wdata = 8'h00; step();
    clr = 1'b1; step();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1; step();
    n_vec++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL midclr_rst busy=%b rvalid=%b exp 1 0", busy0, rvalid0);
    end
    rst = 1'b0;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 40) begin step(); cnt++; end
    n_vec++;
    if (cnt !== D) begin
      n_err++; $display("FAIL midclr_length got %0d exp 16", cnt);
    end
    re = 1'b1;
    for (int i = 0; i < D; i++) begin
      raddr = 4'(D - 1 - i); step();
      n_vec++;
      if (rdata0 !== IV || rdata0 !== m_rd_old) begin
        n_err++; $display("FAIL midclr_word addr %0d got %h exp a5", D - 1 - i, rdata0);
      end
    end
    re = 1'b0; step();
  endtask

  task automatic test_legacy();
    we_b = 1'b1; waddr_b = 4'd5; wdata_b = 1'b1; wmask_b = 1'b1; re_b = 1'b1; raddr_b = 4'd5;
    #1;
    n_vec++;
    if (rdata_b !== 1'b0 || rvalid_b !== 1'b1) begin
      n_err++; $display("FAIL leg_before_edge got %b/%b exp 0/1", rdata_b, rvalid_b);
    end
    step();
    we_b = 1'b0;
    #1;
    n_vec++;
    if (rdata_b !== 1'b1 || rvalid_b !== 1'b1) begin
      n_err++; $display("FAIL leg_after_edge got %b/%b exp 1/1", rdata_b, rvalid_b);
    end
    re_b = 1'b0;
    #1;
    n_vec++;
    if (rvalid_b !== 1'b0) begin
      n_err++; $display("FAIL leg_rvalid_follows got %b exp 0", rvalid_b);
    end
    for (int i = 0; i < 150; i++) begin
      we_b = 1'($urandom); re_b = 1'($urandom); wdata_b = 1'($urandom); wmask_b = 1'($urandom);
      waddr_b = 4'($urandom); raddr_b = 4'($urandom);
      #1;
      n_vec++;
      if (rdata_b !== mb_mem[raddr_b] || rvalid_b !== (re_b && mb_left == 0) || busy_b !== 1'b0) begin
        n_err++;
        $display("FAIL leg_random cyc %0d got %b/%b exp %b/%b", i, rdata_b, rvalid_b,
                 mb_mem[raddr_b], re_b);
      end
      step();
    end
    we_b = 1'b0; re_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_rdw();
    test_random();
    test_runtime_clr();
    test_reset_mid_clear();
    test_legacy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
